// File: rtl/cfg_serial_pkg.sv
// Shared widths, lane indices and FSM state type for the serial configuration transmitter.
package cfg_serial_pkg;

    localparam int unsigned VREF_W = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CONV_W = 8;
    localparam int unsigned COMP_W = 6;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned LANE_VREF = 0;
    localparam int unsigned LANE_DATA = 1;
    localparam int unsigned LANE_CONV = 2;
    localparam int unsigned LANE_COMP = 3;

    // Longest frame is the widest payload plus its leading marker bit.
    function automatic int unsigned frame_max_len(input int unsigned a, input int unsigned b,
                                                  input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m + 1;
    endfunction

    localparam int unsigned MAX_LEN = frame_max_len(VREF_W, DATA_W, CONV_W, COMP_W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

endpackage

// File: rtl/cfg_serial_tx_if.sv
// Parallel request / serial response bundle of cfg_serial_tx.
// lane_mask exists only when CFG_SERIAL_TX_MASK_EN is defined.
interface cfg_serial_tx_if #(
    parameter int unsigned VREF_W = cfg_serial_pkg::VREF_W,
    parameter int unsigned DATA_W = cfg_serial_pkg::DATA_W,
    parameter int unsigned CONV_W = cfg_serial_pkg::CONV_W,
    parameter int unsigned COMP_W = cfg_serial_pkg::COMP_W
);
    logic              start;
    logic [VREF_W-1:0] vref_i;
    logic [DATA_W-1:0] data_i;
    logic [CONV_W-1:0] conver_i;
    logic [COMP_W-1:0] comp_i;
`ifdef CFG_SERIAL_TX_MASK_EN
    logic [3:0]        lane_mask;
`endif
    logic              out_vref;
    logic              out_data;
    logic              out_conver;
    logic              out_comp;
    logic              busy;
    logic              done;

    modport master (
`ifdef CFG_SERIAL_TX_MASK_EN
        output lane_mask,
`endif
        output start,
        output vref_i,
        output data_i,
        output conver_i,
        output comp_i,
        input  out_vref,
        input  out_data,
        input  out_conver,
        input  out_comp,
        input  busy,
        input  done
    );

    modport slave (
`ifdef CFG_SERIAL_TX_MASK_EN
        input  lane_mask,
`endif
        input  start,
        input  vref_i,
        input  data_i,
        input  conver_i,
        input  comp_i,
        output out_vref,
        output out_data,
        output out_conver,
        output out_comp,
        output busy,
        output done
    );

endinterface

// File: rtl/cfg_ser_lane.sv
// One serial lane: shadow shift register loaded with {payload, marker}, emptied LSB first.
module cfg_ser_lane #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic         en_i,
    input  logic [W-1:0] payload_i,
    output logic         ser_o
);

    logic [W:0] sh_q;
    logic [W:0] sh_d;

    // Zero fill means a drained lane idles low until the transfer ends.
    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = en_i ? {payload_i, 1'b1} : '0;
        end else if (shift_i) begin
            sh_d = {1'b0, sh_q[W:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign ser_o = sh_q[0];

endmodule

// File: rtl/cfg_serial_tx.sv
// Serial configuration transmitter: four parallel words out on four marker-led serial lines.
// Optional per-lane masking is compiled in with CFG_SERIAL_TX_MASK_EN.
module cfg_serial_tx
    import cfg_serial_pkg::*;
#(
    parameter int unsigned VREF_W = cfg_serial_pkg::VREF_W,
    parameter int unsigned DATA_W = cfg_serial_pkg::DATA_W,
    parameter int unsigned CONV_W = cfg_serial_pkg::CONV_W,
    parameter int unsigned COMP_W = cfg_serial_pkg::COMP_W
) (
    input  logic           clk,
    input  logic           rst,
    cfg_serial_tx_if.slave bus
);

    localparam int unsigned MaxLen = frame_max_len(VREF_W, DATA_W, CONV_W, COMP_W);
    localparam int unsigned CntW   = $clog2(MaxLen + 1);

    state_e                state_q;
    state_e                state_d;
    logic [CntW-1:0]       cnt_q;
    logic [CntW-1:0]       cnt_d;
    logic                  busy_q;
    logic                  done_q;
    logic                  load;
    logic                  shift;
    logic [NUM_LANES-1:0]  lane_en;
    logic [NUM_LANES-1:0]  ser;

`ifdef CFG_SERIAL_TX_MASK_EN
    assign lane_en = ~bus.lane_mask;
`else
    assign lane_en = '1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(MaxLen - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // busy/done come from next state so they line up with the lane registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    cfg_ser_lane #(
        .W (VREF_W)
    ) u_lane_vref (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .shift_i   (shift),
        .en_i      (lane_en[LANE_VREF]),
        .payload_i (bus.vref_i),
        .ser_o     (ser[LANE_VREF])
    );

    cfg_ser_lane #(
        .W (DATA_W)
    ) u_lane_data (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .shift_i   (shift),
        .en_i      (lane_en[LANE_DATA]),
        .payload_i (bus.data_i),
        .ser_o     (ser[LANE_DATA])
    );

    cfg_ser_lane #(
        .W (CONV_W)
    ) u_lane_conv (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .shift_i   (shift),
        .en_i      (lane_en[LANE_CONV]),
        .payload_i (bus.conver_i),
        .ser_o     (ser[LANE_CONV])
    );

    cfg_ser_lane #(
        .W (COMP_W)
    ) u_lane_comp (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .shift_i   (shift),
        .en_i      (lane_en[LANE_COMP]),
        .payload_i (bus.comp_i),
        .ser_o     (ser[LANE_COMP])
    );

    assign bus.out_vref   = ser[LANE_VREF];
    assign bus.out_data   = ser[LANE_DATA];
    assign bus.out_conver = ser[LANE_CONV];
    assign bus.out_comp   = ser[LANE_COMP];
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_cfg_serial_tx.sv
// Scoreboard bench for cfg_serial_tx; covers the lane mask when CFG_SERIAL_TX_MASK_EN is defined.
module tb_cfg_serial_tx;
    import cfg_serial_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cfg_serial_tx_if bus ();

    cfg_serial_tx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [5:0] v;
        logic       cap_chk;
        logic [8:0] cconv;
        logic [6:0] ccomp;
        string      tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic [5:0] act;
    int n_cmp = 0;
    int n_err = 0;

    // Receiver-side capture shift registers; each freezes once its marker lands in bit 0.
    logic       cap_rst_n;
    logic [8:0] cap_conv;
    logic [6:0] cap_comp;
    always_ff @(posedge clk) begin
        if (!cap_rst_n) begin
            cap_conv <= '0;
            cap_comp <= '0;
        end else begin
            if (!cap_conv[0]) cap_conv <= {bus.out_conver, cap_conv[8:1]};
            if (!cap_comp[0]) cap_comp <= {bus.out_comp, cap_comp[6:1]};
        end
    end

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            act = {bus.out_vref, bus.out_data, bus.out_conver, bus.out_comp, bus.busy, bus.done};
            n_cmp++;
            if (act !== mon_e.v) begin
                n_err++;
                $display("FAIL %s: got %b required %b (vref,data,conver,comp,busy,done) t=%0t",
                         mon_e.tag, act, mon_e.v, $time);
            end
            if (mon_e.cap_chk) begin
                n_cmp++;
                if ({cap_conv, cap_comp} !== {mon_e.cconv, mon_e.ccomp}) begin
                    n_err++;
                    $display("FAIL %s-capture: got conv=%h comp=%h required conv=%h comp=%h",
                             mon_e.tag, cap_conv, cap_comp, mon_e.cconv, mon_e.ccomp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion before 200000");
        $fatal(1);
    end

    task automatic push_exp(input logic [5:0] v, input logic cap_chk, input logic [8:0] cconv,
                            input logic [6:0] ccomp, input string tag);
        exp_t e;
        e.v       = v;
        e.cap_chk = cap_chk;
        e.cconv   = cconv;
        e.ccomp   = ccomp;
        e.tag     = tag;
        sb.push_back(e);
    endtask

    // One clock edge; the expectation is for the cycle that edge starts.
    task automatic tick(input logic [5:0] v, input string tag);
        @(posedge clk);
        #1;
        push_exp(v, 1'b0, '0, '0, tag);
    endtask

    function automatic logic lane_bit(input logic [7:0] p, input int w, input int k);
        if (k == 0) return 1'b1;
        if (k <= w) return p[k-1];
        return 1'b0;
    endfunction

    function automatic logic [5:0] frame_vec(input int c, input logic [3:0] v, input logic [7:0] d,
                                             input logic [7:0] cv, input logic [5:0] cp,
                                             input logic [3:0] m);
        logic [5:0] r;
        int k;
        r = '0;
        if (c < 1 || c > 10) return r;
        k = c - 1;
        r[5] = !m[0] && lane_bit({4'b0, v}, 4, k);
        r[4] = !m[1] && lane_bit(d, 8, k);
        r[3] = !m[2] && lane_bit(cv, 8, k);
        r[2] = !m[3] && lane_bit({2'b0, cp}, 6, k);
        r[1] = 1'b1;
        r[0] = (c == 10);
        return r;
    endfunction

    task automatic set_payload(input logic [3:0] v, input logic [7:0] d, input logic [7:0] cv,
                               input logic [5:0] cp);
        bus.vref_i   = v;
        bus.data_i   = d;
        bus.conver_i = cv;
        bus.comp_i   = cp;
    endtask

    task automatic run_frame(input logic [3:0] v, input logic [7:0] d, input logic [7:0] cv,
                             input logic [5:0] cp, input logic [3:0] m, input string tag);
        set_payload(v, d, cv, cp);
`ifdef CFG_SERIAL_TX_MASK_EN
        bus.lane_mask = m;
`endif
        bus.start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick(frame_vec(c, v, d, cv, cp, m), $sformatf("%s-c%0d", tag, c));
            if (c == 1) bus.start = 1'b0;
        end
        tick(6'b0, {tag, "-idle"});
    endtask

    logic [0:9] hv, hd, hc, hp;

    initial begin
        rst       = 1'b0;
        cap_rst_n = 1'b0;
        bus.start = 1'b1;
        set_payload(4'h0, 8'h00, 8'h00, 6'h00);
`ifdef CFG_SERIAL_TX_MASK_EN
        bus.lane_mask = 4'b0000;
`endif

        // Reset held with start high: nothing may start.
        repeat (3) tick(6'b0, "reset");
        rst       = 1'b1;
        bus.start = 1'b0;
        repeat (2) tick(6'b0, "post_reset");

        // Basic frame, hand-written expected streams.
        hv = 10'b1010100000;
        hd = 10'b1101001010;
        hc = 10'b1000000000;
        hp = 10'b1000000000;
        set_payload(4'hA, 8'hA5, 8'h00, 6'h00);
        bus.start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick({hv[c-1], hd[c-1], hc[c-1], hp[c-1], 1'b1, c == 10}, $sformatf("basic-c%0d", c));
            if (c == 1) bus.start = 1'b0;
        end
        tick(6'b0, "basic-idle");

        // Loopback into capture registers.
        cap_rst_n = 1'b1;
        run_frame(4'h0, 8'h00, 8'h3C, 6'h2B, 4'b0000, "loop");
        @(posedge clk);
        #1;
        push_exp(6'b0, 1'b1, {8'h3C, 1'b1}, {6'h2B, 1'b1}, "loop");

        // Payload change and start re-pulse while busy are both ignored.
        set_payload(4'h5, 8'h96, 8'h81, 6'h15);
        bus.start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick(frame_vec(c, 4'h5, 8'h96, 8'h81, 6'h15, 4'b0), $sformatf("busy-c%0d", c));
            if (c == 1) bus.start = 1'b0;
            if (c == 2) set_payload(4'hA, 8'h69, 8'h7E, 6'h2A);
            if (c == 4) bus.start = 1'b1;
            if (c == 5) bus.start = 1'b0;
        end
        repeat (3) tick(6'b0, "busy-idle");

        // Reset mid-transfer, then a clean frame.
        set_payload(4'hF, 8'hFF, 8'hFF, 6'h3F);
        bus.start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick(frame_vec(c, 4'hF, 8'hFF, 8'hFF, 6'h3F, 4'b0), $sformatf("midrst-c%0d", c));
            if (c == 1) bus.start = 1'b0;
        end
        rst = 1'b0;
        tick(6'b0, "midrst-reset");
        rst = 1'b1;
        repeat (4) tick(6'b0, "midrst-nodone");
        run_frame(4'h6, 8'h5A, 8'hC3, 6'h19, 4'b0000, "after_rst");

`ifdef CFG_SERIAL_TX_MASK_EN
        run_frame(4'hF, 8'h33, 8'hFF, 6'h2D, 4'b0101, "mask");
        run_frame(4'h9, 8'h01, 8'h80, 6'h21, 4'b0000, "unmask");
`endif

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
